// File: rtl/touch_page_ctrl.sv
// Touch-gesture page controller: turns touch-reader gesture codes into frame-buffer
// page selection and committed zoom requests for the scale-factor block.
module touch_page_ctrl #(
   parameter int unsigned NUM_PAGES   = 3,
   parameter int unsigned INIT_PAGE   = 1,
   parameter int unsigned BUFFER_SIZE = 384000,
   parameter int unsigned ADDR_W      = 23,
   parameter int unsigned WRAP        = 0,
   parameter int unsigned TIMEOUT_W   = 9
) (
   input  logic              iCLK,
   input  logic              iRSTN,
   input  logic              iREADY,
   input  logic [9:0]        iREG_X1,
   input  logic [9:0]        iREG_X2,
   input  logic [8:0]        iREG_Y1,
   input  logic [8:0]        iREG_Y2,
   input  logic [1:0]        iREG_TOUCH_COUNT,
   input  logic [7:0]        iREG_GESTURE,
   output logic [ADDR_W-1:0] oRD_ADDR,
   output logic [3:0]        oPAGE,
   output logic              oFACTOR_RSTN,
   output logic              oZOOM_VALID,
   output logic              oZOOM_OUT,
   output logic [9:0]        oX1_START,
   output logic [9:0]        oX2_START,
   output logic [9:0]        oX1_END,
   output logic [9:0]        oX2_END,
   output logic [8:0]        oY1_START,
   output logic [8:0]        oY2_START,
   output logic [8:0]        oY1_END,
   output logic [8:0]        oY2_END
);

   localparam logic [3:0]        LAST_PAGE = 4'(NUM_PAGES - 1);
   localparam logic [3:0]        INIT_PG   = 4'(INIT_PAGE);
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BUFFER_SIZE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(64'(NUM_PAGES - 1) * 64'(BUFFER_SIZE));
   localparam logic [ADDR_W-1:0] INIT_ADDR = ADDR_W'(64'(INIT_PAGE) * 64'(BUFFER_SIZE));

   if (64'(NUM_PAGES) * 64'(BUFFER_SIZE) > (64'd1 << ADDR_W)) begin : g_addr_overflow
      $error("touch_page_ctrl: NUM_PAGES*BUFFER_SIZE does not fit in ADDR_W bits");
   end

   typedef enum logic {ST_IDLE, ST_TOUCH} state_t;

   state_t                state_q;
   logic [2:0]            sync_q;
   logic [TIMEOUT_W-1:0]  wait_q;
   logic                  nxt_q, prv_q, zm_q, zdir_q;
   logic [3:0]            page_q;
   logic [ADDR_W-1:0]     addr_q;
   logic                  frstn_q, zvalid_q, zout_q;
   logic [9:0]            x1s_q, x2s_q, x1e_q, x2e_q;
   logic [8:0]            y1s_q, y2s_q, y1e_q, y2e_q;

   logic rise, fall, is_next, is_prev, is_zoom, is_none, commit;
   logic unused_touch_count;

   assign unused_touch_count = ^iREG_TOUCH_COUNT;

   assign rise    = !sync_q[2] && sync_q[1];
   assign fall    = sync_q[2] && !sync_q[1];
   assign is_next = (iREG_GESTURE == 8'h1C);
   assign is_prev = (iREG_GESTURE == 8'h14);
   assign is_zoom = (iREG_GESTURE[6:3] == 4'b1001);
   assign is_none = (iREG_GESTURE == 8'h00);
   // The ready level for the zoom-close test is the synchronised one, so the
   // closing touch commits in the same cycle its own rise appears and that rise is dropped.
   assign commit  = (state_q == ST_TOUCH) &&
                    (wait_q[TIMEOUT_W-1] || (sync_q[1] && is_none && zm_q));

   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         state_q  <= ST_IDLE;
         sync_q   <= '0;
         wait_q   <= '0;
         nxt_q    <= 1'b0;
         prv_q    <= 1'b0;
         zm_q     <= 1'b0;
         zdir_q   <= 1'b0;
         page_q   <= INIT_PG;
         addr_q   <= INIT_ADDR;
         frstn_q  <= 1'b1;
         zvalid_q <= 1'b0;
         zout_q   <= 1'b0;
         x1s_q <= '0; x2s_q <= '0; x1e_q <= '0; x2e_q <= '0;
         y1s_q <= '0; y2s_q <= '0; y1e_q <= '0; y2e_q <= '0;
      end else begin
         sync_q   <= {sync_q[1:0], iREADY};
         frstn_q  <= 1'b1;
         zvalid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               nxt_q  <= 1'b0;
               prv_q  <= 1'b0;
               zm_q   <= 1'b0;
               wait_q <= '0;
               // The rise that opens a touch is also its first gesture sample.
               if (rise) begin
                  state_q <= ST_TOUCH;
                  x1s_q <= iREG_X1; x2s_q <= iREG_X2;
                  y1s_q <= iREG_Y1; y2s_q <= iREG_Y2;
                  nxt_q <= is_next;
                  prv_q <= is_prev;
                  if (is_zoom) begin
                     zm_q   <= 1'b1;
                     zdir_q <= iREG_GESTURE[0];
                  end
               end
            end
            ST_TOUCH: begin
               if (commit) begin
                  state_q <= ST_IDLE;
                  if (zm_q) begin
                     zvalid_q <= 1'b1;
                     zout_q   <= zdir_q;
                  end else if (prv_q) begin
                     if (page_q != '0) begin
                        page_q  <= page_q - 4'd1;
                        addr_q  <= addr_q - STEP;
                        frstn_q <= 1'b0;
                     end else if (WRAP != 0) begin
                        page_q  <= LAST_PAGE;
                        addr_q  <= LAST_ADDR;
                        frstn_q <= 1'b0;
                     end
                  end else if (nxt_q) begin
                     if (page_q != LAST_PAGE) begin
                        page_q  <= page_q + 4'd1;
                        addr_q  <= addr_q + STEP;
                        frstn_q <= 1'b0;
                     end else if (WRAP != 0) begin
                        page_q  <= '0;
                        addr_q  <= '0;
                        frstn_q <= 1'b0;
                     end
                  end
               end else begin
                  wait_q <= fall ? '0 : wait_q + 1'b1;
                  if (rise) begin
                     if (!zm_q) begin
                        x1s_q <= iREG_X1; x2s_q <= iREG_X2;
                        y1s_q <= iREG_Y1; y2s_q <= iREG_Y2;
                        if (is_next) nxt_q <= 1'b1;
                        if (is_prev) prv_q <= 1'b1;
                     end else if (is_zoom) begin
                        x1e_q <= iREG_X1; x2e_q <= iREG_X2;
                        y1e_q <= iREG_Y1; y2e_q <= iREG_Y2;
                        nxt_q <= 1'b0;
                        prv_q <= 1'b0;
                     end
                     if (is_zoom) begin
                        zm_q   <= 1'b1;
                        zdir_q <= iREG_GESTURE[0];
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign oRD_ADDR     = addr_q;
   assign oPAGE        = page_q;
   assign oFACTOR_RSTN = frstn_q;
   assign oZOOM_VALID  = zvalid_q;
   assign oZOOM_OUT    = zout_q;
   assign oX1_START    = x1s_q;
   assign oX2_START    = x2s_q;
   assign oX1_END      = x1e_q;
   assign oX2_END      = x2e_q;
   assign oY1_START    = y1s_q;
   assign oY2_START    = y2s_q;
   assign oY1_END      = y1e_q;
   assign oY2_END      = y2e_q;

endmodule

// File: tb/tb_touch_page_ctrl.sv
// Bench for touch_page_ctrl: two configurations (saturating 3-page, wrapping 4-page)
// share one randomised touch stream; a gesture-level model feeds a per-instance scoreboard.
module tb_touch_page_ctrl;

   localparam int BS = 384000;

   typedef struct {
      bit          zoom;
      int          page;
      bit          dir;
      logic [75:0] crd;
   } ev_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       ready = 1'b0;
   logic [9:0] x1 = '0, x2 = '0;
   logic [8:0] y1 = '0, y2 = '0;
   logic [1:0] tc = '0;
   logic [7:0] g = '0;

   logic [22:0] addr_w[2];
   logic [3:0]  page_w[2];
   logic        frst_w[2], zv_w[2], zo_w[2];
   logic [9:0]  x1s_w[2], x2s_w[2], x1e_w[2], x2e_w[2];
   logic [8:0]  y1s_w[2], y2s_w[2], y1e_w[2], y2e_w[2];

   ev_t q0[$];
   ev_t q1[$];
   int  checks = 0, passes = 0;
   bit  chk_rst = 0, done = 0, fin = 0;

   // gesture-level model state
   bit         m_in, m_zm, m_nxt, m_prv, m_dir;
   logic [9:0] m_sx1, m_sx2, m_ex1, m_ex2;
   logic [8:0] m_sy1, m_sy2, m_ey1, m_ey2;
   int         m_page[2];

   always #5 clk = ~clk;

   touch_page_ctrl #(.NUM_PAGES(3), .INIT_PAGE(1), .BUFFER_SIZE(BS), .ADDR_W(23), .WRAP(0), .TIMEOUT_W(9)) u_dut0 (
      .iCLK(clk), .iRSTN(rstn), .iREADY(ready), .iREG_X1(x1), .iREG_X2(x2), .iREG_Y1(y1), .iREG_Y2(y2),
      .iREG_TOUCH_COUNT(tc), .iREG_GESTURE(g), .oRD_ADDR(addr_w[0]), .oPAGE(page_w[0]),
      .oFACTOR_RSTN(frst_w[0]), .oZOOM_VALID(zv_w[0]), .oZOOM_OUT(zo_w[0]),
      .oX1_START(x1s_w[0]), .oX2_START(x2s_w[0]), .oX1_END(x1e_w[0]), .oX2_END(x2e_w[0]),
      .oY1_START(y1s_w[0]), .oY2_START(y2s_w[0]), .oY1_END(y1e_w[0]), .oY2_END(y2e_w[0]));

   touch_page_ctrl #(.NUM_PAGES(4), .INIT_PAGE(0), .BUFFER_SIZE(BS), .ADDR_W(23), .WRAP(1), .TIMEOUT_W(9)) u_dut1 (
      .iCLK(clk), .iRSTN(rstn), .iREADY(ready), .iREG_X1(x1), .iREG_X2(x2), .iREG_Y1(y1), .iREG_Y2(y2),
      .iREG_TOUCH_COUNT(tc), .iREG_GESTURE(g), .oRD_ADDR(addr_w[1]), .oPAGE(page_w[1]),
      .oFACTOR_RSTN(frst_w[1]), .oZOOM_VALID(zv_w[1]), .oZOOM_OUT(zo_w[1]),
      .oX1_START(x1s_w[1]), .oX2_START(x2s_w[1]), .oX1_END(x1e_w[1]), .oX2_END(x2e_w[1]),
      .oY1_START(y1s_w[1]), .oY2_START(y2s_w[1]), .oY1_END(y1e_w[1]), .oY2_END(y2e_w[1]));

   function automatic int np(input int i); return (i == 0) ? 3 : 4; endfunction
   function automatic int ip(input int i); return (i == 0) ? 1 : 0; endfunction
   function automatic bit wr(input int i); return (i == 0) ? 1'b0 : 1'b1; endfunction

   function automatic logic [75:0] dut_crd(input int i);
      return {x1s_w[i], x2s_w[i], x1e_w[i], x2e_w[i], y1s_w[i], y2s_w[i], y1e_w[i], y2e_w[i]};
   endfunction

   function automatic logic [75:0] m_crd();
      return {m_sx1, m_sx2, m_ex1, m_ex2, m_sy1, m_sy2, m_ey1, m_ey2};
   endfunction

   function automatic bit zoom_code(input logic [7:0] c);
      return c[6:3] == 4'b1001;
   endfunction

   task automatic check(input string name, input bit ok, input string detail);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   task automatic m_reset();
      m_in = 0; m_zm = 0; m_nxt = 0; m_prv = 0; m_dir = 0;
      m_sx1 = '0; m_sx2 = '0; m_ex1 = '0; m_ex2 = '0;
      m_sy1 = '0; m_sy2 = '0; m_ey1 = '0; m_ey2 = '0;
      for (int i = 0; i < 2; i++) m_page[i] = ip(i);
   endtask

   task automatic m_push(input int i, input ev_t e);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // end of a gesture: zoom wins, otherwise prev over next, with per-config boundary rules
   task automatic m_commit();
      ev_t e;
      int  newp;
      for (int i = 0; i < 2; i++) begin
         e.zoom = m_zm; e.dir = m_dir; e.crd = m_crd();
         newp = -1;
         if (!m_zm && m_prv)
            newp = (m_page[i] > 0) ? m_page[i] - 1 : (wr(i) ? np(i) - 1 : -1);
         else if (!m_zm && m_nxt)
            newp = (m_page[i] < np(i) - 1) ? m_page[i] + 1 : (wr(i) ? 0 : -1);
         if (newp >= 0) m_page[i] = newp;
         e.page = m_page[i];
         if (m_zm || newp >= 0) m_push(i, e);
      end
      m_in = 0;
   endtask

   task automatic m_touch(input logic [7:0] c, input logic [9:0] a, b, input logic [8:0] p, q);
      if (m_in && m_zm && c == 8'h00) begin
         m_commit();
      end else begin
         if (!m_in) begin
            m_in = 1; m_zm = 0; m_nxt = 0; m_prv = 0;
         end
         if (!m_zm) begin
            m_sx1 = a; m_sx2 = b; m_sy1 = p; m_sy2 = q;
            if (c == 8'h1C) m_nxt = 1;
            if (c == 8'h14) m_prv = 1;
         end else if (zoom_code(c)) begin
            m_ex1 = a; m_ex2 = b; m_ey1 = p; m_ey2 = q;
            m_nxt = 0; m_prv = 0;
         end
         if (zoom_code(c)) begin
            m_zm = 1; m_dir = c[0];
         end
      end
   endtask

   task automatic touch(input logic [7:0] c, input int xa, xb, ya, yb, h, l);
      g = c; x1 = 10'(xa); x2 = 10'(xb); y1 = 9'(ya); y2 = 9'(yb);
      tc = 2'($urandom_range(0, 3));
      ready = 1'b1;
      m_touch(c, x1, x2, y1, y2);
      repeat (h) @(posedge clk);
      #1 ready = 1'b0;
      repeat (l) @(posedge clk);
      #1;
   endtask

   task automatic timeout_end();
      if (m_in) m_commit();
      repeat (280) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; ready = 1'b0;
      m_reset();
      chk_rst = 1;
      @(negedge clk);
      @(posedge clk);
      #1 chk_rst = 0; rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rand_g();
      case ($urandom_range(0, 5))
         0: return 8'h1C;
         1: return 8'h14;
         2, 5: return {1'($urandom_range(0, 1)), 4'b1001, 3'($urandom_range(0, 7))};
         3: return 8'h00;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      do_reset();
      // next, then saturate on the 3-page config
      touch(8'h1C, 10, 20, 30, 40, 3, 5);   timeout_end();
      touch(8'h1C, 11, 21, 31, 41, 3, 5);   timeout_end();
      // prev from page 0 after reset
      do_reset();
      touch(8'h14, 1, 2, 3, 4, 4, 6);       timeout_end();
      touch(8'h14, 5, 6, 7, 8, 4, 6);       timeout_end();
      // zoom with start/end and a closing 0x00 touch
      touch(8'h49, 100, 300, 50, 200, 5, 10);
      touch(8'h49, 50, 400, 20, 300, 5, 10);
      touch(8'h00, 0, 0, 0, 0, 5, 10);
      timeout_end();
      // next then zoom in one gesture: zoom only
      touch(8'h1C, 7, 8, 9, 10, 4, 8);
      touch(8'h4A, 70, 80, 90, 100, 4, 8);
      timeout_end();
      // slow toggling keeps the timeout from firing mid-gesture
      for (int k = 0; k < 3; k++) touch(8'h1C, 1, 1, 1, 1, 100, 100);
      timeout_end();
      for (int s = 0; s < 30; s++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int t = 0; t < n; t++)
            touch(rand_g(), $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 511), $urandom_range(0, 511),
                  $urandom_range(3, 20), $urandom_range(3, 60));
         if ($urandom_range(0, 1) == 1)
            touch(8'h00, 0, 0, 0, 0, $urandom_range(3, 20), $urandom_range(3, 60));
         timeout_end();
      end
      // reset in the middle of a touch aborts it
      touch(8'h49, 33, 44, 55, 66, 3, 5);
      g = 8'h1C; ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 do_reset();
      repeat (300) @(posedge clk);
      #1;
      touch(8'h1C, 9, 9, 9, 9, 3, 5);       timeout_end();
      done = 1;
   end

   always @(negedge clk) begin
      ev_t e;
      bit  ok, empty;
      if (chk_rst) begin
         for (int i = 0; i < 2; i++) begin
            check("reset_page", page_w[i] == 4'(ip(i)),
                  $sformatf("inst%0d got %0d want %0d", i, page_w[i], ip(i)));
            check("reset_addr", addr_w[i] == 23'(ip(i) * BS),
                  $sformatf("inst%0d got %0d want %0d", i, addr_w[i], ip(i) * BS));
            check("reset_pulses", frst_w[i] && !zv_w[i] && !zo_w[i],
                  $sformatf("inst%0d got frst=%0d zv=%0d zo=%0d want 1 0 0", i, frst_w[i], zv_w[i], zo_w[i]));
            check("reset_coords", dut_crd(i) == m_crd(),
                  $sformatf("inst%0d got %h want %h", i, dut_crd(i), m_crd()));
         end
      end
      if (rstn && !chk_rst) begin
         for (int i = 0; i < 2; i++) begin
            if (!frst_w[i] || zv_w[i]) begin
               empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
               if (empty) begin
                  check("unexpected_event", 1'b0,
                        $sformatf("inst%0d got frst=%0d zv=%0d page=%0d want no event", i, frst_w[i], zv_w[i], page_w[i]));
               end else begin
                  e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  if (e.zoom)
                     ok = zv_w[i] && frst_w[i] && page_w[i] == 4'(e.page) && zo_w[i] == e.dir && dut_crd(i) == e.crd;
                  else
                     ok = !zv_w[i] && !frst_w[i] && page_w[i] == 4'(e.page) && addr_w[i] == 23'(e.page * BS);
                  check(e.zoom ? "zoom_event" : "page_event", ok,
                        $sformatf("inst%0d got zv=%0d frst=%0d page=%0d addr=%0d dir=%0d crd=%h want zoom=%0d page=%0d addr=%0d dir=%0d crd=%h",
                                  i, zv_w[i], frst_w[i], page_w[i], addr_w[i], zo_w[i], dut_crd(i),
                                  e.zoom, e.page, e.page * BS, e.dir, e.crd));
               end
            end
         end
      end
      if (done && !fin) begin
         fin = 1;
         check("missing_events0", q0.size() == 0, $sformatf("got %0d pending want 0", q0.size()));
         check("missing_events1", q1.size() == 0, $sformatf("got %0d pending want 0", q1.size()));
         for (int i = 0; i < 2; i++)
            check("final_page", page_w[i] == 4'(m_page[i]) && addr_w[i] == 23'(m_page[i] * BS),
                  $sformatf("inst%0d got page=%0d addr=%0d want page=%0d addr=%0d",
                            i, page_w[i], addr_w[i], m_page[i], m_page[i] * BS));
         $display("%0d/%0d checks passed", passes, checks);
         $finish;
      end
   end

endmodule

// File: doc/touch_page_ctrl.md
# touch_page_ctrl

Parametrised touch-gesture controller for the photo-viewer display path. It sits between the I2C touch-register reader and the frame-buffer read side and turns gesture codes into page selection, with a page count and wrap-around mode that are set by parameters. Zoom requests are committed with start/end coordinates to an external scale-factor block. It generates `oRD_ADDR` for the current page and issues a one-cycle reset to the scale-factor block on every page change.

## Interface
- `NUM_PAGES`, 3: number of frame buffers. Legal range is 2..16.
- `INIT_PAGE`, 1: page selected after reset. Legal range is 0..NUM_PAGES-1.
- `BUFFER_SIZE`, 384000 (800*480): words per page.
- `ADDR_W`, 23: width of `oRD_ADDR`.
- `WRAP`, 0: 1 means next-from-last goes to page 0 and prev-from-0 goes to the last page. 0 means saturate.
- `TIMEOUT_W`, 9: width of the touch timeout counter. Timeout fires when the MSB sets, i.e. 2^(TIMEOUT_W-1) cycles.
- `iCLK` in 1: clock.
- `iRSTN` in 1: reset, asynchronous, active-low.
- `iREADY` in 1: touch-data-valid level from the touch reader. Asynchronous to `iCLK`.
- `iREG_X1`, `iREG_X2` in 10: touch point X coordinates.
- `iREG_Y1`, `iREG_Y2` in 9: touch point Y coordinates.
- `iREG_TOUCH_COUNT` in 2: number of touch points. Unused except in the test plan.
- `iREG_GESTURE` in 8: gesture code.
- `oRD_ADDR` out ADDR_W: base address of the current page, equal to `page*BUFFER_SIZE`.
- `oPAGE` out 4: current page index.
- `oFACTOR_RSTN` out 1: one-cycle low pulse on each page change.
- `oZOOM_VALID` out 1: one-cycle pulse when a zoom gesture is committed.
- `oZOOM_OUT` out 1: zoom direction. Valid while `oZOOM_VALID` is high.
- `oX1_START`, `oX2_START`, `oX1_END`, `oX2_END` out 10: zoom X coordinates.
- `oY1_START`, `oY2_START`, `oY1_END`, `oY2_END` out 9: zoom Y coordinates.

## Operation
- **Gesture decode**
  - next: 0x1C
  - prev: 0x14
  - zoom: `iREG_GESTURE[6:3]`=4'b1001, with `oZOOM_OUT`=`iREG_GESTURE[0]`
  - none: 0x00
- **Input sync and edges:** `iREADY` passes through a 3-flop shift register `d[2:0]`.
  - Rise = `!d[2] && d[1]`.
  - Fall = `d[2] && !d[1]`.
- **State machine, IDLE / TOUCH:**
  - **IDLE:** clears the `nxt`, `prv` and `zm` flags. On rise, go to TOUCH and set `wait_cnt` to 0.
  - **TOUCH:** `wait_cnt` clears on fall and increments otherwise.
  - **TOUCH, each rise:**
    - If `zm`=0, latch X1/X2/Y1/Y2 into the START coordinates, and set `nxt` or `prv` from the current code.
    - If `zm`=1 and the code is zoom, latch the coordinates into the END outputs, and clear `nxt` and `prv`.
    - A zoom code sets `zm`=1 and latches the zoom direction.
  - **TOUCH exit:** `commit` = (`wait_cnt` MSB) OR (`iREADY` && code==0x00 && `zm`). On `commit`, return to IDLE.
- **Actions on `commit`:**
  - `zm`=1: `oZOOM_VALID` pulses. No page change.
  - Otherwise `prv`=1: decrement page. `prv` has priority over `nxt`.
  - Otherwise `nxt`=1: increment page.
- **Page boundaries:**
  - Decrement at page 0: with WRAP=1 go to NUM_PAGES-1. With WRAP=0 hold and do not pulse `oFACTOR_RSTN`.
  - Increment at the last page: with WRAP=1 go to 0. With WRAP=0 hold and do not pulse.
- **Address generation:** no multiplier.
  - Increment adds BUFFER_SIZE to the address accumulator.
  - Decrement subtracts BUFFER_SIZE.
  - Wrap loads the constant 0 or (NUM_PAGES-1)*BUFFER_SIZE.
- **Parameter check:** an elaboration-time check fails if NUM_PAGES*BUFFER_SIZE exceeds 2^ADDR_W.

## Timing
- **Reset values:**
  - `oPAGE`=INIT_PAGE
  - `oRD_ADDR`=INIT_PAGE*BUFFER_SIZE
  - `oFACTOR_RSTN`=1
  - `oZOOM_VALID`=0 and `oZOOM_OUT`=0
  - all coordinate outputs 0
  - state IDLE, `d`=0, `wait_cnt`=0
- **Latency:** `iREADY` rising to the rise event is 2 cycles. IDLE to TOUCH is 1 cycle after that.
- **Same-edge updates:** `oPAGE`, `oRD_ADDR`, `oFACTOR_RSTN` low and `oZOOM_VALID` high are all registered on the clock edge following `commit`.
- **Pulse widths:** `oFACTOR_RSTN` and `oZOOM_VALID` each stay active for exactly 1 cycle.
- **Coordinate hold:** coordinate outputs hold their values until the next latch.
- **Rise during commit:** a rise in the `commit` cycle is ignored. It does not re-enter TOUCH until the following rise.
- **Reset mid-TOUCH:** aborts with no pulse, and page and address return to their INIT values.

## Test plan
- **Next, then hold:** defaults, gesture 0x1C, `iREADY` high 3 cycles, then low → after 256 cycles exactly one `oFACTOR_RSTN` low pulse, `oPAGE` 1→2, `oRD_ADDR`=768000. A second 0x1C touch gives no pulse and values unchanged (saturate).
- **Prev at page 0:** INIT_PAGE=0, WRAP=1, NUM_PAGES=4, gesture 0x14 → `oPAGE`=3, `oRD_ADDR`=1152000, one pulse.
- **Zoom:** rise with 0x49 at X1=100, Y1=50, X2=300, Y2=200. Second rise with 0x49 at X1=50, Y1=20, X2=400, Y2=300. Then `iREADY` high with gesture 0x00 → single `oZOOM_VALID`, `oZOOM_OUT`=1, START/END match the two touches, `oPAGE` unchanged.
- **Mixed sequence:** 0x1C then zoom code in one touch → zoom only, no page change.
- **Reset mid-touch:** `iRSTN` low during TOUCH → all outputs at reset values, no pulses.
- **Timeout counter:** `iREADY` toggling every 100 cycles → falls keep clearing `wait_cnt`. Commit comes only 256 cycles after the last fall.
